// File: rtl/ads1256_controller.sv
// ADS1256 system controller: reset, DRATE setup, then round-robin
// single-ended channel scan issuing one 24-bit command per SPI transaction.
//
// Ports:
//   clock_i / reset_i         system clock, async active-high reset
//   enable_i                  run request (level)
//   drate_i                   DRATE register value, latched on leaving IDLE
//   transaction_start_o       one-cycle start pulse to the SPI layer
//   cmd_o                     {opcode, byte2, byte3}, stable start..done
//   transaction_done_i        one-cycle done pulse from the SPI layer
//   data_i                    conversion data, valid with done of RDATA
//   sample_o / channel_o      last captured conversion and its channel
//   sample_valid_o            one-cycle pulse on new sample
//   busy_o                    high outside IDLE and ERROR
//   error_o                   transaction timeout flag
module ads1256_controller #(
  parameter int NUM_CH         = 8,
  parameter int SETTLE_CYCLES  = 2000,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [7:0]    drate_i,
  output logic          transaction_start_o,
  output logic [23:0]   cmd_o,
  input  logic          transaction_done_i,
  input  logic [23:0]   data_i,
  output logic [23:0]   sample_o,
  output logic [CW-1:0] channel_o,
  output logic          sample_valid_o,
  output logic          busy_o,
  output logic          error_o
);

  localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                        SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNTW = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_DRATE,
    S_MUX,
    S_SYNC,
    S_WAKE,
    S_RDATA,
    S_ERROR
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            issue_q;
  logic [CNTW-1:0] cnt_q;
  logic [7:0]      drate_q;
  logic [CW-1:0]   ch_q;
  logic [23:0]     sample_q;
  logic [CW-1:0]   chan_q;
  logic            valid_q;

  logic            cmd_st;
  logic            wait_ph;
  logic            got_done;
  logic            tmo;
  logic [3:0]      mux_ch;

  always_comb begin
    cmd_st = 1'b0;
    unique case (state_q)
      S_RST, S_DRATE, S_MUX,
      S_SYNC, S_WAKE, S_RDATA: cmd_st = 1'b1;
      default:                 cmd_st = 1'b0;
    endcase
  end

  // The first cycle of a command state is its issue cycle; the rest
  // is the wait phase, where done is accepted and the timeout runs.
  // cnt_q holds the number of cycles elapsed since the start pulse.
  assign wait_ph  = cmd_st && !issue_q;
  assign got_done = wait_ph && transaction_done_i;
  assign tmo      = wait_ph && !transaction_done_i &&
                    (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  // State register and datapath.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      issue_q  <= 1'b0;
      cnt_q    <= '0;
      drate_q  <= '0;
      ch_q     <= '0;
      sample_q <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= (state_d != state_q) && (state_d != S_IDLE) &&
                 (state_d != S_SETTLE) && (state_d != S_ERROR);
      valid_q <= 1'b0;

      if (state_d == S_SETTLE && state_q != S_SETTLE)
        cnt_q <= '0;
      else if (issue_q)
        cnt_q <= CNTW'(1);
      else if (state_q == S_SETTLE || wait_ph)
        cnt_q <= cnt_q + CNTW'(1);

      if (state_q == S_IDLE && state_d == S_RST) begin
        drate_q <= drate_i;
        ch_q    <= '0;
      end

      if (got_done && state_q == S_RDATA) begin
        sample_q <= data_i;
        chan_q   <= ch_q;
        valid_q  <= 1'b1;
        if (ch_q == CW'(NUM_CH - 1))
          ch_q <= '0;
        else
          ch_q <= ch_q + CW'(1);
      end
    end
  end

  // Next-state logic. A command boundary is an accepted done; with
  // enable_i low there, the sequence parks in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i)
          state_d = S_RST;
      end
      S_SETTLE: begin
        if (!enable_i)
          state_d = S_IDLE;
        else if (cnt_q == CNTW'(SETTLE_CYCLES - 1))
          state_d = S_DRATE;
      end
      S_ERROR: begin
        if (!enable_i)
          state_d = S_IDLE;
      end
      default: begin
        if (tmo) begin
          state_d = S_ERROR;
        end else if (got_done) begin
          if (!enable_i) begin
            state_d = S_IDLE;
          end else begin
            unique case (state_q)
              S_RST:   state_d = S_SETTLE;
              S_DRATE: state_d = S_MUX;
              S_MUX:   state_d = S_SYNC;
              S_SYNC:  state_d = S_WAKE;
              S_WAKE:  state_d = S_RDATA;
              S_RDATA: state_d = S_MUX;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs, decoded from registered state only.
  assign mux_ch = 4'(ch_q);

  always_comb begin
    cmd_o = 24'h000000;
    unique case (state_q)
      S_RST:   cmd_o = 24'hFE0000;
      S_DRATE: cmd_o = {16'h5300, drate_q};
      S_MUX:   cmd_o = {16'h5100, mux_ch, 4'h8};
      S_SYNC:  cmd_o = 24'hFC0000;
      S_WAKE:  cmd_o = 24'h000000;
      S_RDATA: cmd_o = 24'h010000;
      default: cmd_o = 24'h000000;
    endcase
    transaction_start_o = cmd_st && issue_q;
    busy_o              = (state_q != S_IDLE) && (state_q != S_ERROR);
    error_o             = (state_q == S_ERROR);
    sample_o            = sample_q;
    channel_o           = chan_q;
    sample_valid_o      = valid_q;
  end

endmodule
